// File: rtl/four_bit_threshold_monitor.sv
// Alarm hysteresis on a stream of comparator results: TRIP_COUNT consecutive "gr"
// results raise the alarm, CLEAR_COUNT consecutive "lt" results drop it.
module four_bit_threshold_monitor #(
    parameter int TRIP_COUNT  = 3,
    parameter int CLEAR_COUNT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmp_valid,
    input  logic       cmp_eq,
    input  logic       cmp_gr,
    input  logic       cmp_lt,
    input  logic       clr_stats,
    output logic       alarm,
    output logic [1:0] state,
    output logic [3:0] run_cnt,
    output logic [7:0] trip_total,
    output logic       err
);

    typedef enum logic [1:0] {
        NORMAL       = 2'b00,
        PENDING_TRIP = 2'b01,
        ALARM        = 2'b10,
        PENDING_CLR  = 2'b11
    } state_t;

    localparam logic [4:0] TRIP_N = 5'(TRIP_COUNT);
    localparam logic [4:0] CLR_N  = 5'(CLEAR_COUNT);

    state_t     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic [7:0] trip_q, trip_d;
    logic       err_q, err_d;
    logic       alarm_q, alarm_d;

    logic       one_hot;
    logic       accept;
    logic       illegal;
    logic       enter_alarm;
    logic [4:0] run_inc;

    // Exactly one of the three comparator flags is high.
    assign one_hot = (cmp_eq ^ cmp_gr ^ cmp_lt) & ~(cmp_eq & cmp_gr & cmp_lt);
    assign accept  = cmp_valid & one_hot;
    assign illegal = cmp_valid & ~one_hot;
    assign run_inc = {1'b0, run_q} + 5'd1;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        enter_alarm = 1'b0;
        if (accept) begin
            unique case (state_q)
                NORMAL: begin
                    run_d = '0;
                    if (cmp_gr) begin
                        if (TRIP_COUNT == 1) begin
                            state_d     = ALARM;
                            enter_alarm = 1'b1;
                        end else begin
                            state_d = PENDING_TRIP;
                            run_d   = 4'd1;
                        end
                    end
                end
                PENDING_TRIP: begin
                    if (cmp_gr) begin
                        if (run_inc == TRIP_N) begin
                            state_d     = ALARM;
                            run_d       = '0;
                            enter_alarm = 1'b1;
                        end else begin
                            run_d = run_inc[3:0];
                        end
                    end else begin
                        state_d = NORMAL;
                        run_d   = '0;
                    end
                end
                ALARM: begin
                    run_d = '0;
                    if (cmp_lt) begin
                        if (CLEAR_COUNT == 1) begin
                            state_d = NORMAL;
                        end else begin
                            state_d = PENDING_CLR;
                            run_d   = 4'd1;
                        end
                    end
                end
                PENDING_CLR: begin
                    if (cmp_lt) begin
                        if (run_inc == CLR_N) begin
                            state_d = NORMAL;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc[3:0];
                        end
                    end else begin
                        state_d = ALARM;
                        run_d   = '0;
                    end
                end
            endcase
        end

        // Statistics clear takes priority over a coincident trip or error.
        if (clr_stats) begin
            trip_d = '0;
            err_d  = 1'b0;
        end else begin
            trip_d = (enter_alarm && trip_q != '1) ? trip_q + 8'd1 : trip_q;
            err_d  = err_q | illegal;
        end

        alarm_d = (state_d == ALARM) || (state_d == PENDING_CLR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NORMAL;
            run_q   <= '0;
            trip_q  <= '0;
            err_q   <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            trip_q  <= trip_d;
            err_q   <= err_d;
            alarm_q <= alarm_d;
        end
    end

    assign alarm      = alarm_q;
    assign state      = state_q;
    assign run_cnt    = run_q;
    assign trip_total = trip_q;
    assign err        = err_q;

endmodule

// File: tb/tb_four_bit_threshold_monitor.sv
// Bench for four_bit_threshold_monitor: two instances (3/2 and 1/1 thresholds) on
// shared stimulus, checked every cycle against a run-length model plus literal pins.
module tb_four_bit_threshold_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_valid = 1'b0, cmp_eq = 1'b0, cmp_gr = 1'b0, cmp_lt = 1'b0, clr_stats = 1'b0;

    logic       alarm_a, err_a, alarm_b, err_b;
    logic [1:0] state_a, state_b;
    logic [3:0] run_a, run_b;
    logic [7:0] trip_a, trip_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    four_bit_threshold_monitor #(.TRIP_COUNT(3), .CLEAR_COUNT(2)) dut_a (
        .clk(clk), .rst(rst), .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .cmp_gr(cmp_gr),
        .cmp_lt(cmp_lt), .clr_stats(clr_stats), .alarm(alarm_a), .state(state_a),
        .run_cnt(run_a), .trip_total(trip_a), .err(err_a)
    );

    four_bit_threshold_monitor #(.TRIP_COUNT(1), .CLEAR_COUNT(1)) dut_b (
        .clk(clk), .rst(rst), .cmp_valid(cmp_valid), .cmp_eq(cmp_eq), .cmp_gr(cmp_gr),
        .cmp_lt(cmp_lt), .clr_stats(clr_stats), .alarm(alarm_b), .state(state_b),
        .run_cnt(run_b), .trip_total(trip_b), .err(err_b)
    );

    // Model: alarm level plus length of the run pushing it the other way.
    int m_trip_n[2]  = '{3, 1};
    int m_clear_n[2] = '{2, 1};
    bit m_alarm[2];
    int m_run[2];
    int m_trips[2];
    bit m_err[2];

    function automatic int m_state(int k);
        if (m_alarm[k]) return (m_run[k] != 0) ? 3 : 2;
        return (m_run[k] != 0) ? 1 : 0;
    endfunction

    function automatic void check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_alarm[k] = 1'b0;
                m_run[k]   = 0;
                m_trips[k] = 0;
                m_err[k]   = 1'b0;
            end else begin
                bit legal;
                bit new_trip;
                legal    = cmp_valid && (int'(cmp_eq) + int'(cmp_gr) + int'(cmp_lt) == 1);
                new_trip = 1'b0;
                if (legal) begin
                    if (!m_alarm[k]) begin
                        m_run[k] = cmp_gr ? m_run[k] + 1 : 0;
                        if (m_run[k] == m_trip_n[k]) begin
                            m_alarm[k] = 1'b1;
                            m_run[k]   = 0;
                            new_trip   = 1'b1;
                        end
                    end else begin
                        m_run[k] = cmp_lt ? m_run[k] + 1 : 0;
                        if (m_run[k] == m_clear_n[k]) begin
                            m_alarm[k] = 1'b0;
                            m_run[k]   = 0;
                        end
                    end
                end
                if (cmp_valid && !legal) m_err[k] = 1'b1;
                if (clr_stats) begin
                    m_trips[k] = 0;
                    m_err[k]   = 1'b0;
                end else if (new_trip && m_trips[k] < 255) begin
                    m_trips[k]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("A.alarm", int'(alarm_a), int'(m_alarm[0]));
            check("A.state", int'(state_a), m_state(0));
            check("A.run_cnt", int'(run_a), m_run[0]);
            check("A.trip_total", int'(trip_a), m_trips[0]);
            check("A.err", int'(err_a), int'(m_err[0]));
            check("B.alarm", int'(alarm_b), int'(m_alarm[1]));
            check("B.state", int'(state_b), m_state(1));
            check("B.run_cnt", int'(run_b), m_run[1]);
            check("B.trip_total", int'(trip_b), m_trips[1]);
            check("B.err", int'(err_b), int'(m_err[1]));
        end
    end

    // One clock: drive at the falling edge, return at the next falling edge.
    task automatic cyc(input bit r, input bit v, input bit e, input bit g, input bit l,
                       input bit c = 1'b0);
        rst = r; cmp_valid = v; cmp_eq = e; cmp_gr = g; cmp_lt = l; clr_stats = c;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cmp_valid = 1'b0; cmp_eq = 1'b0; cmp_gr = 1'b0; cmp_lt = 1'b0;
        clr_stats = 1'b0;
    endtask

    task automatic gr(input bit c = 1'b0); cyc(0, 1, 0, 1, 0, c); endtask
    task automatic lt(); cyc(0, 1, 0, 0, 1); endtask
    task automatic eq(); cyc(0, 1, 1, 0, 0); endtask
    task automatic idle(); cyc(0, 0, 0, 0, 0); endtask
    task automatic reset(); cyc(1, 0, 0, 0, 0); endtask

    initial begin
        @(negedge clk);
        cyc(1, 1, 0, 1, 0);
        chk_en = 1'b1;
        check("reset.state", int'(state_a), 0);
        check("reset.alarm", int'(alarm_a), 0);
        check("reset.trip", int'(trip_a), 0);

        // Three consecutive gr trip the 3/2 instance.
        gr(); check("t1.state", int'(state_a), 1); check("t1.run", int'(run_a), 1);
        gr(); check("t2.state", int'(state_a), 1); check("t2.run", int'(run_a), 2);
        gr(); check("t3.state", int'(state_a), 2); check("t3.alarm", int'(alarm_a), 1);
        check("t3.trip", int'(trip_a), 1);

        // eq breaks a run; idle cycles hold it.
        reset();
        gr(); idle(); gr(); idle(); check("idle.run", int'(run_a), 2);
        eq(); check("eq.state", int'(state_a), 0);
        gr(); idle(); gr(); check("rerun.alarm", int'(alarm_a), 0);
        gr(); check("rerun.alarm2", int'(alarm_a), 1); check("rerun.trip", int'(trip_a), 1);

        // Clear hysteresis from ALARM.
        lt(); check("c1.state", int'(state_a), 3);
        gr(); check("c2.state", int'(state_a), 2);
        lt(); check("c3.state", int'(state_a), 3); check("c3.alarm", int'(alarm_a), 1);
        lt(); check("c4.state", int'(state_a), 0); check("c4.alarm", int'(alarm_a), 0);
        check("c4.trip", int'(trip_a), 1);

        // Illegal encodings set err without disturbing the run.
        reset();
        gr(); gr();
        cyc(0, 1, 0, 1, 1);
        check("ill.err", int'(err_a), 1); check("ill.state", int'(state_a), 1);
        check("ill.run", int'(run_a), 2);
        cyc(0, 1, 0, 0, 0); cyc(0, 1, 1, 1, 1);
        gr(); check("ill.trip", int'(trip_a), 1);
        cyc(0, 0, 0, 0, 0, 1);
        check("clr.err", int'(err_a), 0); check("clr.trip", int'(trip_a), 0);
        check("clr.alarm", int'(alarm_a), 1);
        cyc(0, 1, 1, 1, 0, 1); check("clr_vs_ill.err", int'(err_a), 0);

        // Saturation of trip_total, then clear winning over a trip.
        reset();
        for (int i = 0; i < 256; i++) begin
            gr(); gr(); gr(); lt(); lt();
        end
        check("sat.trip", int'(trip_a), 255);
        gr(); gr(); gr(1'b1);
        check("clr_vs_trip.trip", int'(trip_a), 0); check("clr_vs_trip.alarm", int'(alarm_a), 1);

        // Reset mid PENDING_CLEAR overrides a coincident lt.
        lt(); check("pc.state", int'(state_a), 3);
        cyc(1, 1, 0, 0, 1);
        check("rst.state", int'(state_a), 0); check("rst.alarm", int'(alarm_a), 0);
        check("rst.run", int'(run_a), 0);
        gr(); check("b.alarm", int'(alarm_b), 1); check("b.trip", int'(trip_b), 1);
        lt(); check("b.clear", int'(alarm_b), 0);
        idle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d, expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/four_bit_threshold_monitor.md
FOUR_BIT_THRESHOLD_MONITOR -- requirements
Module: four_bit_threshold_monitor

Interface
REQ-001 Parameter TRIP_COUNT, default 3: consecutive accepted "gr" results needed to raise the alarm; legal range 1..15.
REQ-002 Parameter CLEAR_COUNT, default 2: consecutive accepted "lt" results needed to drop the alarm; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 cmp_valid  input  1  cmp_eq/cmp_gr/cmp_lt carry a new comparison result (sample a vs threshold b) this cycle.
REQ-006 cmp_eq  input  1  a == b, from the upstream 4-bit magnitude comparator.
REQ-007 cmp_gr  input  1  a > b, from the upstream comparator.
REQ-008 cmp_lt  input  1  a < b, from the upstream comparator.
REQ-009 clr_stats  input  1  one-cycle request to clear trip_total and err.
REQ-010 alarm  output  1  registered; high while state is ALARM or PENDING_CLEAR.
REQ-011 state  output  2  registered FSM state: NORMAL=00, PENDING_TRIP=01, ALARM=10, PENDING_CLEAR=11.
REQ-012 run_cnt  output  4  registered length of the current qualifying run.
REQ-013 trip_total  output  8  registered count of entries into ALARM; saturates at 255.
REQ-014 err  output  1  registered, sticky; set by an illegal comparator encoding.

Function
REQ-015 A result is accepted only on a cycle with cmp_valid=1 and exactly one of cmp_eq, cmp_gr, cmp_lt high; cycles with cmp_valid=0 leave state and run_cnt unchanged.
REQ-016 On cmp_valid=1 with zero, two or three of cmp_eq/cmp_gr/cmp_lt high, the block sets err=1 on the next edge, ignores the result, and leaves state, run_cnt and trip_total unchanged.
REQ-017 NORMAL on accepted gr: if TRIP_COUNT==1, go to ALARM with run_cnt=0; otherwise go to PENDING_TRIP with run_cnt=1.
REQ-018 NORMAL on accepted eq or lt: stay in NORMAL with run_cnt=0.
REQ-019 PENDING_TRIP on accepted gr: if run_cnt+1==TRIP_COUNT, go to ALARM with run_cnt=0; otherwise run_cnt increments.
REQ-020 PENDING_TRIP on accepted eq or lt: go to NORMAL with run_cnt=0.
REQ-021 ALARM on accepted lt: if CLEAR_COUNT==1, go to NORMAL with run_cnt=0; otherwise go to PENDING_CLEAR with run_cnt=1.
REQ-022 ALARM on accepted eq or gr: stay in ALARM with run_cnt=0.
REQ-023 PENDING_CLEAR on accepted lt: if run_cnt+1==CLEAR_COUNT, go to NORMAL with run_cnt=0; otherwise run_cnt increments.
REQ-024 PENDING_CLEAR on accepted eq or gr: go to ALARM with run_cnt=0; this does not increment trip_total.
REQ-025 eq is neutral: it breaks any run in progress and never advances one.
REQ-026 Latency: alarm changes on the same edge that accepts the qualifying result, so it is visible in the following cycle; there is no combinational path from the inputs to any output.
REQ-027 trip_total increments only on a transition from NORMAL or PENDING_TRIP into ALARM, and holds at 255 once it reaches 255.
REQ-028 clr_stats=1 clears trip_total and err on the next edge.
REQ-029 If clr_stats coincides with a trip, clear wins and trip_total=0; if it coincides with an illegal encoding, clear wins and err=0.
REQ-030 clr_stats does not affect state, run_cnt or alarm.

Reset
REQ-031 rst=1 at a rising edge forces state=NORMAL, alarm=0, run_cnt=0, trip_total=0, err=0, overriding all other inputs including an in-progress run or an active ALARM.
REQ-032 Inputs are ignored during every cycle in which rst=1; the first result accepted after rst falls is evaluated from NORMAL.

Verification (TRIP_COUNT=3, CLEAR_COUNT=2 unless noted)
REQ-033 Three accepted gr in consecutive valid cycles -> state 01 (run 1), 01 (run 2), then 10; alarm=1 from the cycle after the 3rd edge; trip_total=1.
REQ-034 Sequence gr, gr, eq, gr, gr, gr with idle cycles (cmp_valid=0) interleaved -> eq returns state to 00; alarm rises only after the final gr; idle cycles hold run_cnt; trip_total=1.
REQ-035 From ALARM: lt, gr, lt, lt -> state 11, 10, 11, 00; alarm=0 only after the final lt; trip_total unchanged.
REQ-036 cmp_valid=1 with cmp_gr=1 and cmp_lt=1 while in PENDING_TRIP with run 2 -> err=1; state and run_cnt unchanged; a following gr still trips; clr_stats then sets err=0 and trip_total=0 while alarm stays 1.
REQ-037 Drive 256 full trip/clear cycles -> trip_total holds at 255; assert clr_stats on the same edge as a trip -> trip_total=0.
REQ-038 rst=1 asserted mid-PENDING_CLEAR, with cmp_valid=1 and lt present -> all outputs at reset values next cycle; with TRIP_COUNT=1, a single gr after reset -> alarm=1 next cycle.
